// File: rtl/dmem_access_arbiter.sv
// rtl/dmem_access_arbiter.sv - shares single-port dmem between the core data bus and the host CSR window
// Core has default priority; a saturating host wait counter forces a host grant after HOST_MAX_WAIT cycles.
module dmem_access_arbiter #(
  parameter int ADDR_WIDTH    = 12,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic                  cpu_write,
  input  logic                  cpu_read,
  input  logic [31:0]           cpu_writedata,
  input  logic [3:0]            cpu_be,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_waitreq,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_write,
  input  logic                  host_read,
  input  logic [31:0]           host_writedata,
  output logic [31:0]           host_readdata,
  output logic                  host_waitreq,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  host_starve
);

  typedef enum logic {IDLE, RD_DATA} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

  state_t                state, state_nxt;
  owner_t                rd_owner, rd_owner_nxt;
  logic [7:0]            wait_cnt, wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  cpu_req, host_req;
  logic                  host_win, cpu_win, host_done;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0]};

  assign cpu_req  = cpu_read | cpu_write;
  assign host_req = host_read | host_write;

  // Read data is a plain pass-through; only the owner's RD_DATA cycle makes it valid.
  assign cpu_readdata  = mem_rdata;
  assign host_readdata = mem_rdata;

  always_comb begin
    state_nxt    = state;
    rd_owner_nxt = rd_owner;
    host_win     = 1'b0;
    cpu_win      = 1'b0;
    host_done    = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = addr_q;
    mem_be       = be_q;
    mem_wdata    = wdata_q;
    cpu_waitreq  = cpu_req;
    host_waitreq = host_req;

    if (!reset) begin
      case (state)
        IDLE: begin
          host_win = host_req && (!cpu_req || host_starve);
          cpu_win  = cpu_req && !host_win;
          if (host_win) begin
            mem_addr  = host_addr;
            mem_be    = 4'hF;
            mem_wdata = host_writedata;
            if (host_write) begin
              mem_wr       = 1'b1;
              host_waitreq = 1'b0;
              host_done    = 1'b1;
            end else begin
              state_nxt    = RD_DATA;
              rd_owner_nxt = OWN_HOST;
            end
          end else if (cpu_win) begin
            mem_addr  = cpu_addr[ADDR_WIDTH+1:2];
            mem_be    = cpu_be;
            mem_wdata = cpu_writedata;
            if (cpu_write) begin
              mem_wr      = 1'b1;
              cpu_waitreq = 1'b0;
            end else begin
              state_nxt    = RD_DATA;
              rd_owner_nxt = OWN_CPU;
            end
          end
        end
        RD_DATA: begin
          state_nxt = IDLE;
          if (rd_owner == OWN_HOST) begin
            host_waitreq = 1'b0;
            host_done    = 1'b1;
          end else begin
            cpu_waitreq = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (!host_req || host_done) begin
      wait_cnt_nxt = 8'd0;
    end else if (wait_cnt < MAX_WAIT) begin
      wait_cnt_nxt = wait_cnt + 8'd1;
    end else begin
      wait_cnt_nxt = wait_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_owner    <= OWN_CPU;
      wait_cnt    <= 8'd0;
      host_starve <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
    end else begin
      state       <= state_nxt;
      rd_owner    <= rd_owner_nxt;
      wait_cnt    <= wait_cnt_nxt;
      host_starve <= (wait_cnt_nxt == MAX_WAIT);
      addr_q      <= mem_addr;
      wdata_q     <= mem_wdata;
      be_q        <= mem_be;
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb/tb_dmem_access_arbiter.sv - randomized bench for dmem_access_arbiter against a transaction-level model
module tb_dmem_access_arbiter;

  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_writedata = '0, cpu_readdata;
  logic        cpu_write = 1'b0, cpu_read = 1'b0, cpu_waitreq;
  logic [3:0]  cpu_be = '0;
  logic [11:0] host_addr = '0;
  logic        host_write = 1'b0, host_read = 1'b0, host_waitreq;
  logic [31:0] host_writedata = '0, host_readdata;
  logic [11:0] mem_addr;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        host_starve;

  dmem_access_arbiter #(.ADDR_WIDTH(12), .HOST_MAX_WAIT(MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_writedata(cpu_writedata), .cpu_be(cpu_be),
    .cpu_readdata(cpu_readdata), .cpu_waitreq(cpu_waitreq),
    .host_addr(host_addr), .host_write(host_write), .host_read(host_read),
    .host_writedata(host_writedata), .host_readdata(host_readdata),
    .host_waitreq(host_waitreq),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .host_starve(host_starve)
  );

  always #5 clk = ~clk;

  // dmem stand-in: byte-enabled writes, one-cycle registered read
  logic [31:0] dmem [4096];
  always @(posedge clk) begin
    if (mem_wr)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= dmem[mem_addr];
  end

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] ref_mem [4096];
  int          pend, wcnt, grant;
  bit          have_last;
  logic [11:0] last_addr, g_addr;
  logic [31:0] last_wdata, g_data;
  logic [3:0]  g_be;
  bit          g_wr, cr, hr, e_cw, e_hw, e_wr, done_h;
  bit          cpu_busy, host_busy;
  int          rst_left, cpu_rate, host_rate, starve_hits;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dmem[i]    = 32'd0;
      ref_mem[i] = 32'd0;
    end
    pend = 0; wcnt = 0; have_last = 0; cpu_busy = 0; host_busy = 0;
    rst_left = 3; starve_hits = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 1500) begin cpu_rate = 50; host_rate = 40; end
      else if (cyc < 2500) begin cpu_rate = 100; host_rate = 60; end
      else begin cpu_rate = 70; host_rate = 70; end

      if (rst_left == 0 && cyc > 10 && $urandom_range(99) == 0) rst_left = 1 + $urandom_range(1);
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;

      if (!cpu_busy) begin
        cpu_read = 1'b0; cpu_write = 1'b0;
        if (cyc > 4 && $urandom_range(99) < cpu_rate) begin
          cpu_busy = 1;
          cpu_write = (cpu_rate == 100) ? 1'b1 : 1'($urandom_range(1));
          cpu_read  = !cpu_write || ($urandom_range(3) == 0);
          cpu_addr  = {18'($urandom), 12'($urandom_range(15)), 2'($urandom)};
          cpu_writedata = $urandom;
          cpu_be    = 4'($urandom);
        end
      end
      if (!host_busy) begin
        host_read = 1'b0; host_write = 1'b0;
        if (cyc > 4 && $urandom_range(99) < host_rate) begin
          host_busy = 1;
          host_write = (cpu_rate == 100) ? 1'b0 : 1'($urandom_range(1));
          host_read  = !host_write;
          host_addr  = 12'($urandom_range(15));
          host_writedata = $urandom;
        end
      end

      @(negedge clk);
      cr = cpu_read | cpu_write;
      hr = host_read | host_write;
      e_cw = cr; e_hw = hr; e_wr = 0; grant = 0; done_h = 0; g_wr = 0;
      chk("host_starve", 32'(host_starve), 32'(wcnt == MAX));
      if (host_starve) starve_hits++;

      if (!reset) begin
        if (pend == 1) begin
          e_cw = 0;
          chk("cpu_readdata", cpu_readdata, ref_mem[cpu_addr[13:2]]);
        end else if (pend == 2) begin
          e_hw = 0; done_h = 1;
          chk("host_readdata", host_readdata, ref_mem[host_addr]);
        end else if (hr && (!cr || wcnt == MAX)) begin
          grant = 2; g_addr = host_addr; g_be = 4'hF; g_data = host_writedata; g_wr = host_write;
        end else if (cr) begin
          grant = 1; g_addr = cpu_addr[13:2]; g_be = cpu_be; g_data = cpu_writedata; g_wr = cpu_write;
        end
      end

      if (grant != 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(g_addr));
        chk("mem_be", 32'(mem_be), 32'(g_be));
        if (g_wr) begin
          e_wr = 1;
          chk("mem_wdata", mem_wdata, g_data);
          for (int b = 0; b < 4; b++)
            if (g_be[b]) ref_mem[g_addr][8*b +: 8] = g_data[8*b +: 8];
          if (grant == 1) e_cw = 0; else begin e_hw = 0; done_h = 1; end
        end
        have_last = 1; last_addr = g_addr; last_wdata = g_data;
      end else if (have_last && !reset) begin
        chk("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
        chk("mem_wdata_hold", mem_wdata, last_wdata);
      end
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("cpu_waitreq", 32'(cpu_waitreq), 32'(e_cw));
      chk("host_waitreq", 32'(host_waitreq), 32'(e_hw));

      if (reset || !hr || done_h) wcnt = 0;
      else if (wcnt < MAX) wcnt++;
      pend = reset ? 0 : ((grant != 0 && !g_wr) ? grant : 0);
      if (reset) have_last = 0;
      if (cr && !e_cw) cpu_busy = 0;
      if (hr && !e_hw) host_busy = 0;
    end

    chk("starve_seen", 32'(starve_hits > 0), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
